// File: rtl/parc_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// parc_mem_responder_pkg
// Shared definitions for the PARCv2 memory request/response messages:
// field positions inside the 67-bit request and 35-bit response, the type
// and len encodings, and the byte-lane helpers used by the responder.
// ---------------------------------------------------------------------------
package parc_mem_responder_pkg;

    localparam int unsigned c_req_msg_w     = 67;
    localparam int unsigned c_resp_msg_w    = 35;

    localparam int unsigned c_req_type_bit  = 66;
    localparam int unsigned c_req_addr_msb  = 65;
    localparam int unsigned c_req_addr_lsb  = 34;
    localparam int unsigned c_req_len_msb   = 33;
    localparam int unsigned c_req_len_lsb   = 32;
    localparam int unsigned c_req_data_msb  = 31;
    localparam int unsigned c_req_data_lsb  = 0;

    localparam int unsigned c_resp_type_bit = 34;
    localparam int unsigned c_resp_len_msb  = 33;
    localparam int unsigned c_resp_len_lsb  = 32;
    localparam int unsigned c_resp_data_msb = 31;

    typedef enum logic {
        MEM_TYPE_READ  = 1'b0,
        MEM_TYPE_WRITE = 1'b1
    } mem_type_e;

    typedef enum logic [1:0] {
        MEM_LEN_WORD = 2'd0,
        MEM_LEN_BYTE = 2'd1,
        MEM_LEN_HALF = 2'd2
    } mem_len_e;

    // Replace the lanes selected by len/offset with the low bytes of wdata.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  len,
                                               input logic [1:0]  off);
        logic [31:0] w;
        w = old_word;
        case (len)
            MEM_LEN_BYTE: w[{off, 3'b000} +: 8]        = wdata[7:0];
            MEM_LEN_HALF: w[{off[1], 4'b0000} +: 16]   = wdata[15:0];
            MEM_LEN_WORD: w                            = wdata;
            default:      w                            = wdata;
        endcase
        return w;
    endfunction

    // Shift the selected lanes down to bit 0 and zero-extend.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  len,
                                                 input logic [1:0]  off);
        logic [31:0] r;
        case (len)
            MEM_LEN_BYTE: r = {24'h000000, word[{off, 3'b000} +: 8]};
            MEM_LEN_HALF: r = {16'h0000, word[{off[1], 4'b0000} +: 16]};
            MEM_LEN_WORD: r = word;
            default:      r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vc_Queue_pf.sv
// ---------------------------------------------------------------------------
// vc_Queue_pf
// Parameterized val/rdy FIFO. Storage is a register array; the dequeue
// message is read straight from the head entry. Pointers wrap modulo
// p_depth and a separate count tells full from empty.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   enq_val/enq_rdy/msg   enqueue side
//   deq_val/deq_rdy/msg   dequeue side (msg = head register)
//   count                 current occupancy
// ---------------------------------------------------------------------------
module vc_Queue_pf #(
    parameter int p_depth = 4,
    parameter int p_width = 35
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enq_val,
    output logic                           enq_rdy,
    input  logic [p_width-1:0]             enq_msg,
    output logic                           deq_val,
    input  logic                           deq_rdy,
    output logic [p_width-1:0]             deq_msg,
    output logic [$clog2(p_depth+1)-1:0]   count
);

    localparam int c_ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int c_cnt_w = $clog2(p_depth + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(p_depth - 1);

    logic [p_width-1:0] mem_q [p_depth];
    logic [c_ptr_w-1:0] head_q, head_d, tail_q, tail_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               enq_fire_s, deq_fire_s;

    assign enq_rdy    = (count_q < c_cnt_w'(p_depth));
    assign deq_val    = (count_q != {c_cnt_w{1'b0}});
    assign deq_msg    = mem_q[head_q];
    assign count      = count_q;
    assign enq_fire_s = enq_val && enq_rdy;
    assign deq_fire_s = deq_val && deq_rdy;

    // Next pointer and occupancy values; simultaneous enq+deq nets to zero.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        if (deq_fire_s) begin
            head_d = (head_q == c_last_ptr) ? {c_ptr_w{1'b0}} : head_q + c_ptr_w'(1);
        end else begin
            head_d = head_q;
        end
        if (enq_fire_s) begin
            tail_d = (tail_q == c_last_ptr) ? {c_ptr_w{1'b0}} : tail_q + c_ptr_w'(1);
        end else begin
            tail_d = tail_q;
        end
        count_d = count_q + c_cnt_w'(enq_fire_s) - c_cnt_w'(deq_fire_s);
    end

    // Pointer, count and storage registers; storage clears so the head reads 0 in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= {c_ptr_w{1'b0}};
            tail_q  <= {c_ptr_w{1'b0}};
            count_q <= {c_cnt_w{1'b0}};
            for (int i = 0; i < p_depth; i++) begin
                mem_q[i] <= {p_width{1'b0}};
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq_fire_s) begin
                mem_q[tail_q] <= enq_msg;
            end
        end
    end

endmodule

// File: rtl/parc_mem_responder.sv
// ---------------------------------------------------------------------------
// parc_mem_responder
// Single-port PARCv2 memory responder: a write-first word array accessed in
// the accept cycle, a p_latency-deep delay line, and a response FIFO that
// honours memresp_rdy backpressure.
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   memreq_val/rdy, memreq_msg[66:0]  request channel {type,addr,len,data}
//   memresp_val/rdy, memresp_msg[34:0] response channel {type,len,data}
// ---------------------------------------------------------------------------
module parc_mem_responder
    import parc_mem_responder_pkg::*;
#(
    parameter int p_mem_words   = 1024,
    parameter int p_latency     = 2,
    parameter int p_queue_depth = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [66:0] memreq_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [34:0] memresp_msg
);

    localparam int c_idx_w = $clog2(p_mem_words);
    localparam int c_cnt_w = $clog2(p_queue_depth + 1);
    localparam int c_inf_w = c_cnt_w + 1;

    logic [31:0]              mem_q [p_mem_words];
    logic [c_idx_w-1:0]       idx_s;
    logic [1:0]               off_s;
    logic [1:0]               req_len_s;
    logic                     req_type_s;
    logic [31:0]              req_data_s;
    logic                     accept_s;
    logic [31:0]              rd_word_s, wr_word_s, resp_data_s;
    logic [c_resp_msg_w-1:0]  resp_s;
    logic                     unused_addr_hi_s;

    logic [p_latency-1:0]                    dl_val_q, dl_val_d;
    logic [p_latency-1:0][c_resp_msg_w-1:0]  dl_msg_q, dl_msg_d;

    logic                     enq_rdy_s, enq_fire_s, deq_fire_s;
    logic [c_cnt_w-1:0]       fifo_count_s;
    logic [c_inf_w-1:0]       dl_cnt_s, fifo_next_s, inflight_s;
    logic                     memreq_rdy_q, memreq_rdy_d;

    assign req_type_s = memreq_msg[c_req_type_bit];
    assign req_len_s  = memreq_msg[c_req_len_msb:c_req_len_lsb];
    assign req_data_s = memreq_msg[c_req_data_msb:c_req_data_lsb];
    assign off_s      = memreq_msg[c_req_addr_lsb +: 2];
    assign idx_s      = memreq_msg[c_req_addr_lsb + 2 +: c_idx_w];
    // Address bits above the array index are ignored by design.
    assign unused_addr_hi_s = ^memreq_msg[c_req_addr_msb:c_req_addr_lsb + 2 + c_idx_w];

    assign accept_s   = memreq_val && memreq_rdy_q;
    assign memreq_rdy = memreq_rdy_q;
    assign enq_fire_s = dl_val_q[p_latency-1] && enq_rdy_s;
    assign deq_fire_s = memresp_val && memresp_rdy;

    // Array access and response formation for the request on the bus this cycle.
    always_comb begin
        rd_word_s = mem_q[idx_s];
        wr_word_s = lane_merge(rd_word_s, req_data_s, req_len_s, off_s);
        if (req_type_s == MEM_TYPE_WRITE) begin
            resp_data_s = 32'h00000000;
        end else begin
            resp_data_s = lane_extract(rd_word_s, req_len_s, off_s);
        end
        resp_s = {req_type_s, req_len_s, resp_data_s};
    end

    // Word array write port; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && accept_s && (req_type_s == MEM_TYPE_WRITE)) begin
            mem_q[idx_s] <= wr_word_s;
        end
    end

    // Delay line shift: stage 0 captures the accepted response.
    always_comb begin
        dl_val_d = dl_val_q;
        dl_msg_d = dl_msg_q;
        for (int i = p_latency - 1; i > 0; i--) begin
            dl_val_d[i] = dl_val_q[i-1];
            dl_msg_d[i] = dl_msg_q[i-1];
        end
        dl_val_d[0] = accept_s;
        dl_msg_d[0] = resp_s;
    end

    // Next-cycle inflight count; ready is registered from it so it never
    // depends combinationally on memreq_val or memresp_rdy.
    always_comb begin
        dl_cnt_s = {c_inf_w{1'b0}};
        for (int i = 0; i < p_latency; i++) begin
            dl_cnt_s = dl_cnt_s + c_inf_w'(dl_val_d[i]);
        end
        fifo_next_s  = c_inf_w'(fifo_count_s) + c_inf_w'(enq_fire_s) - c_inf_w'(deq_fire_s);
        inflight_s   = dl_cnt_s + fifo_next_s;
        memreq_rdy_d = (inflight_s < c_inf_w'(p_queue_depth));
    end

    // Delay-line and request-ready registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dl_val_q     <= {p_latency{1'b0}};
            dl_msg_q     <= {(p_latency * c_resp_msg_w){1'b0}};
            memreq_rdy_q <= 1'b0;
        end else begin
            dl_val_q     <= dl_val_d;
            dl_msg_q     <= dl_msg_d;
            memreq_rdy_q <= memreq_rdy_d;
        end
    end

    vc_Queue_pf #(
        .p_depth (p_queue_depth),
        .p_width (c_resp_msg_w)
    ) u_resp_q (
        .clk     (clk),
        .reset   (reset),
        .enq_val (dl_val_q[p_latency-1]),
        .enq_rdy (enq_rdy_s),
        .enq_msg (dl_msg_q[p_latency-1]),
        .deq_val (memresp_val),
        .deq_rdy (memresp_rdy),
        .deq_msg (memresp_msg),
        .count   (fifo_count_s)
    );

endmodule

// File: tb/tb_parc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_parc_mem_responder
// Self-checking bench: a byte-addressed reference memory plus an ordered
// queue of expected responses (tagged with their accept cycle) predicts
// ready, valid and message on every cycle; directed tests add fixed checks.
// ---------------------------------------------------------------------------
module tb_parc_mem_responder;

    localparam int c_lat   = 2;
    localparam int c_depth = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [66:0] memreq_msg;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [34:0] memresp_msg;

    typedef struct {
        logic [34:0] msg;
        int          t;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem [4096];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_deq = 0;
    logic        last_acc;
    logic        last_deq;
    logic [34:0] last_resp;

    parc_mem_responder #(
        .p_mem_words   (1024),
        .p_latency     (c_lat),
        .p_queue_depth (c_depth)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [66:0] req(input logic typ, input logic [1:0] len,
                                        input logic [31:0] addr, input logic [31:0] data);
        return {typ, addr, len, data};
    endfunction

    // Reference memory access: little-endian bytes, address taken modulo array size.
    function automatic logic [34:0] ref_access(input logic [66:0] m);
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rd;
        logic [1:0]  len;
        int          a, nbytes, base;
        addr   = m[65:34];
        len    = m[33:32];
        data   = m[31:0];
        a      = int'(addr % 32'd4096);
        nbytes = (len == 2'd1) ? 1 : ((len == 2'd2) ? 2 : 4);
        base   = a - (a % nbytes);
        rd     = 32'h0;
        if (m[66]) begin
            for (int k = 0; k < nbytes; k++) ref_mem[base + k] = data[8*k +: 8];
            return {1'b1, len, 32'h0};
        end
        for (int k = 0; k < nbytes; k++) rd[8*k +: 8] = ref_mem[base + k];
        return {1'b0, len, rd};
    endfunction

    // One clock: account handshakes, advance, then check outputs #1 after the edge.
    task automatic tick();
        logic        acc, deq, exp_val;
        logic [34:0] resp;
        acc  = memreq_val && memreq_rdy;
        deq  = memresp_val && memresp_rdy;
        resp = 35'h0;
        if (acc && reset) resp = ref_access(memreq_msg);
        if (deq && reset) last_resp = memresp_msg;
        @(posedge clk);
        #1;
        cyc++;
        last_acc = acc && reset;
        last_deq = deq && reset;
        if (!reset) begin
            exp_q.delete();
            chk_eq("rst_req_rdy", {63'h0, memreq_rdy}, 64'h0);
            chk_eq("rst_resp_val", {63'h0, memresp_val}, 64'h0);
            chk_eq("rst_resp_msg", {29'h0, memresp_msg}, 64'h0);
        end else begin
            if (deq) begin
                n_deq++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (acc) exp_q.push_back('{msg: resp, t: cyc});
            exp_val = (exp_q.size() > 0) && ((cyc - exp_q[0].t) >= c_lat);
            chk_eq("req_rdy", {63'h0, memreq_rdy}, {63'h0, (exp_q.size() < c_depth)});
            chk_eq("resp_val", {63'h0, memresp_val}, {63'h0, exp_val});
            if (exp_val) chk_eq("resp_msg", {29'h0, memresp_msg}, {29'h0, exp_q[0].msg});
        end
    endtask

    task automatic send(input logic typ, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] data);
        memreq_val = 1'b1;
        memreq_msg = req(typ, len, addr, data);
        last_acc   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) chk_eq("send_timeout", 64'h0, 64'h1);
        memreq_val = 1'b0;
    endtask

    // Wait for memresp_val, report the cycle it appeared, then take the response.
    task automatic wait_resp(output int vc);
        vc = -1;
        for (int i = 0; i < 50; i++) begin
            if (memresp_val) begin
                vc = cyc;
                break;
            end
            tick();
        end
        if (vc < 0) chk_eq("resp_timeout", 64'h0, 64'h1);
        else tick();
    endtask

    task automatic drain();
        memresp_rdy = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
        chk_eq("drain", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        int          a, v, nacc, ndq, drops, first, last, acc_end, start, base_deq, nops;
        int          dc [4];
        logic [31:0] addr, hi;
        reset       = 1'b0;
        memreq_val  = 1'b0;
        memreq_msg  = 67'h0;
        memresp_rdy = 1'b1;
        last_resp   = 35'h0;
        dc          = '{0, 0, 0, 0};
        acc_end     = 0;

        // Reset and release.
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        chk_eq("rdy_after_release", {63'h0, memreq_rdy}, 64'h1);

        // Preload the random/backpressure region 0x300..0x33f.
        for (int i = 0; i < 16; i++) send(1'b1, 2'd0, 32'h300 + 32'(4*i), 32'h1000_0000 + 32'(i) * 32'h0101_0101);
        drain();

        // Word write/read with latency.
        send(1'b1, 2'd0, 32'h100, 32'hdeadbeef);
        a = cyc;
        wait_resp(v);
        chk_eq("wr_latency", 64'(v - a), 64'(c_lat));
        chk_eq("wr_resp", {29'h0, last_resp}, {29'h0, 1'b1, 2'd0, 32'h0});
        send(1'b0, 2'd0, 32'h100, 32'h0);
        a = cyc;
        wait_resp(v);
        chk_eq("rd_latency", 64'(v - a), 64'(c_lat));
        chk_eq("rd_resp", {29'h0, last_resp}, {29'h0, 1'b0, 2'd0, 32'hdeadbeef});

        // Subword accesses.
        send(1'b1, 2'd0, 32'h200, 32'h11223344);
        send(1'b1, 2'd1, 32'h201, 32'h000000aa);
        send(1'b0, 2'd0, 32'h200, 32'h0);
        drain();
        chk_eq("sub_word", {29'h0, last_resp}, {29'h0, 1'b0, 2'd0, 32'h1122aa44});
        send(1'b0, 2'd1, 32'h203, 32'h0);
        drain();
        chk_eq("sub_byte", {29'h0, last_resp}, {29'h0, 1'b0, 2'd1, 32'h00000011});
        send(1'b0, 2'd2, 32'h202, 32'h0);
        drain();
        chk_eq("sub_half", {29'h0, last_resp}, {29'h0, 1'b0, 2'd2, 32'h00001122});

        // Read in the cycle right after a write to the same word.
        send(1'b1, 2'd0, 32'h104, 32'h5a5a1234);
        send(1'b0, 2'd0, 32'h104, 32'h0);
        drain();
        chk_eq("raw_read", {29'h0, last_resp}, {29'h0, 1'b0, 2'd0, 32'h5a5a1234});

        // Backpressure: 8 reads against a stalled response channel.
        memresp_rdy = 1'b0;
        nacc = 0;
        for (int i = 0; i < 12; i++) begin
            memreq_val = 1'b1;
            memreq_msg = req(1'b0, 2'd0, 32'h300 + 32'(4*nacc), 32'h0);
            tick();
            if (last_acc) nacc++;
        end
        chk_eq("bp_accepts", 64'(nacc), 64'd4);
        chk_eq("bp_rdy_low", {63'h0, memreq_rdy}, 64'h0);
        chk_eq("bp_head", {29'h0, memresp_msg}, {29'h0, 1'b0, 2'd0, 32'h1000_0000});
        memresp_rdy = 1'b1;
        ndq = 0;
        for (int i = 0; i < 40 && (nacc < 8 || ndq < 8); i++) begin
            memreq_val = (nacc < 8);
            memreq_msg = req(1'b0, 2'd0, 32'h300 + 32'(4*nacc), 32'h0);
            tick();
            if (last_acc) nacc++;
            if (last_deq) begin
                if (ndq < 4) dc[ndq] = cyc;
                ndq++;
            end
        end
        memreq_val = 1'b0;
        chk_eq("bp_resume", 64'(nacc), 64'd8);
        chk_eq("bp_resps", 64'(ndq), 64'd8);
        chk_eq("bp_consec", 64'(dc[3] - dc[0]), 64'd3);
        drain();

        // Full throughput: 16 back-to-back reads.
        nacc = 0; ndq = 0; drops = 0; first = -1; last = -1; start = cyc;
        for (int i = 0; i < 60 && (nacc < 16 || ndq < 16); i++) begin
            memreq_val = (nacc < 16);
            memreq_msg = req(1'b0, 2'd0, 32'h300 + 32'(4*(nacc % 16)), 32'h0);
            if (memreq_val && !memreq_rdy) drops++;
            tick();
            if (last_acc) begin
                nacc++;
                if (nacc == 16) acc_end = cyc;
            end
            if (last_deq) begin
                if (ndq == 0) first = cyc;
                last = cyc;
                ndq++;
            end
        end
        memreq_val = 1'b0;
        chk_eq("tp_rdy_drops", 64'(drops), 64'd0);
        chk_eq("tp_accept_span", 64'(acc_end - start), 64'd16);
        chk_eq("tp_resps", 64'(ndq), 64'd16);
        chk_eq("tp_resp_span", 64'(last - first), 64'd15);

        // Reset with responses in flight.
        send(1'b1, 2'd0, 32'h340, 32'hcafef00d);
        drain();
        memresp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 2'd0, 32'h340, 32'h0);
        base_deq = n_deq;
        reset = 1'b0;
        tick();
        chk_eq("mid_rst_rdy", {63'h0, memreq_rdy}, 64'h0);
        reset = 1'b1;
        tick();
        chk_eq("mid_rst_rdy_rel", {63'h0, memreq_rdy}, 64'h1);
        memresp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk_eq("mid_rst_no_stale", {63'h0, memresp_val}, 64'h0);
        send(1'b0, 2'd0, 32'h340, 32'h0);
        wait_resp(v);
        chk_eq("mid_rst_data", {29'h0, last_resp}, {29'h0, 1'b0, 2'd0, 32'hcafef00d});
        chk_eq("mid_rst_one_resp", 64'(n_deq - base_deq), 64'd1);

        // Random mixed traffic with throttling on both channels.
        nops = 0;
        for (int i = 0; i < 20000 && nops < 1000; i++) begin
            if (!memreq_val && ($urandom_range(0, 3) != 0)) begin
                hi   = $urandom() & 32'hffff_f000;
                addr = hi | (32'h300 + 32'($urandom_range(0, 63)));
                memreq_msg = req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), addr, $urandom());
                memreq_val = 1'b1;
            end
            memresp_rdy = ($urandom_range(0, 9) < 7);
            tick();
            if (last_acc) begin
                nops++;
                memreq_val = 1'b0;
            end
        end
        memreq_val = 1'b0;
        drain();
        chk_eq("rand_ops", 64'(nops), 64'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
